// File: rtl/digit_result_collector_if.sv
// rtl/digit_result_collector_if.sv - classifier-to-collector digit result stream
interface digit_result_collector_if;
    logic       digit_valid;
    logic       digit_ready;
    logic [3:0] digit_class;
    logic       digit_last;

    // classifier side drives results; collector side returns backpressure
    modport master (
        output digit_valid,
        output digit_class,
        output digit_last,
        input  digit_ready
    );

    modport slave (
        input  digit_valid,
        input  digit_class,
        input  digit_last,
        output digit_ready
    );
endinterface

// File: rtl/digit_result_collector.sv
// rtl/digit_result_collector.sv - packs per-frame digit classes into rom_sel, committed on vsync rise
module digit_result_collector #(
    parameter int         HOLD_FRAMES = 8,
    parameter logic [3:0] BLANK_CODE  = 4'hF
) (
    input  logic                     sclk,
    input  logic                     s_rst_n,
    input  logic                     vga_vsync,
    digit_result_collector_if.slave  dig,
    output logic [15:0]              rom_sel,
    output logic                     sel_update,
    output logic                     ovf_o
);
    localparam int              MW         = $clog2(HOLD_FRAMES) + 1;
    localparam logic [MW-1:0]   MISS_LAST  = MW'(HOLD_FRAMES - 1);
    localparam logic [MW-1:0]   MISS_MAX   = {MW{1'b1}};
    localparam logic [15:0]     BLANK_WORD = {4{BLANK_CODE}};

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_DONE    = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     sh_q, sh_d;
    logic [2:0]      wr_idx_q, wr_idx_d;
    logic            ovf_sh_q, ovf_sh_d;
    logic [MW-1:0]   miss_q, miss_d;
    logic            vsync_d;
    logic            ready_q;
    logic [15:0]     rom_sel_d;
    logic            ovf_d;
    logic            upd_d;

    logic            vs_rise;
    logic            accept;
    logic [3:0]      slot_code;

    assign vs_rise         = vga_vsync & ~vsync_d;
    assign accept          = dig.digit_valid & ready_q;
    assign slot_code       = (dig.digit_class <= 4'd9) ? dig.digit_class : BLANK_CODE;
    assign dig.digit_ready = ready_q;

    // previous vsync level for rising-edge detection
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            vsync_d <= 1'b0;
        end else begin
            vsync_d <= vga_vsync;
        end
    end

    // state, shadow word, counters and committed outputs
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q    <= ST_COLLECT;
            sh_q       <= BLANK_WORD;
            wr_idx_q   <= 3'd0;
            ovf_sh_q   <= 1'b0;
            miss_q     <= '0;
            ready_q    <= 1'b0;
            rom_sel    <= BLANK_WORD;
            ovf_o      <= 1'b0;
            sel_update <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            wr_idx_q   <= wr_idx_d;
            ovf_sh_q   <= ovf_sh_d;
            miss_q     <= miss_d;
            ready_q    <= (state_d == ST_COLLECT);
            rom_sel    <= rom_sel_d;
            ovf_o      <= ovf_d;
            sel_update <= upd_d;
        end
    end

    // next-state: collect beats into the shadow, commit or blank on vsync rise
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        wr_idx_d  = wr_idx_q;
        ovf_sh_d  = ovf_sh_q;
        miss_d    = miss_q;
        rom_sel_d = rom_sel;
        ovf_d     = ovf_o;
        upd_d     = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                // a rise while still collecting is a frame without a result
                if (vs_rise) begin
                    if (miss_q == MISS_LAST) begin
                        rom_sel_d = BLANK_WORD;
                        upd_d     = 1'b1;
                        miss_d    = '0;
                    end else if (miss_q != MISS_MAX) begin
                        miss_d = miss_q + MW'(1);
                    end
                end
                if (accept) begin
                    if (wr_idx_q < 3'd4) begin
                        sh_d[{wr_idx_q[1:0], 2'b00} +: 4] = slot_code;
                        wr_idx_d = wr_idx_q + 3'd1;
                    end else begin
                        ovf_sh_d = 1'b1;
                    end
                    if (dig.digit_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // complete result waits here so the overlay only changes at frame start
                if (vs_rise) begin
                    rom_sel_d = sh_q;
                    ovf_d     = ovf_sh_q;
                    upd_d     = 1'b1;
                    sh_d      = BLANK_WORD;
                    wr_idx_d  = 3'd0;
                    ovf_sh_d  = 1'b0;
                    miss_d    = '0;
                    state_d   = ST_COLLECT;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end
endmodule

// File: tb/tb_digit_result_collector.sv
// tb/tb_digit_result_collector.sv - randomized self-checking bench for digit_result_collector
module tb_digit_result_collector;
    localparam int HOLD = 8;

    logic        sclk = 1'b0;
    logic        s_rst_n;
    logic        vga_vsync;
    logic [15:0] rom_sel;
    logic        sel_update;
    logic        ovf_o;

    int total = 0;
    int bad   = 0;

    digit_result_collector_if bus ();

    digit_result_collector #(
        .HOLD_FRAMES (HOLD),
        .BLANK_CODE  (4'hF)
    ) dut (
        .sclk       (sclk),
        .s_rst_n    (s_rst_n),
        .vga_vsync  (vga_vsync),
        .dig        (bus),
        .rom_sel    (rom_sel),
        .sel_update (sel_update),
        .ovf_o      (ovf_o)
    );

    always #5 sclk = ~sclk;

    // reference model: list of accepted classes for the current frame
    int          frame_q[$];
    bit          m_done;
    int          m_miss;
    logic [15:0] m_rom;
    logic        m_ovf;

    function automatic void model_reset();
        frame_q.delete();
        m_done = 0;
        m_miss = 0;
        m_rom  = 16'hFFFF;
        m_ovf  = 1'b0;
    endfunction

    function automatic logic [15:0] pack_frame();
        logic [15:0] w;
        w = 16'h0;
        for (int i = 0; i < 4; i++) begin
            int code;
            if (i < frame_q.size() && frame_q[i] <= 9) code = frame_q[i];
            else code = 15;
            w = w | (16'(code) << (4 * i));
        end
        return w;
    endfunction

    function automatic void model_vs(output bit upd);
        upd = 0;
        if (m_done) begin
            m_rom  = pack_frame();
            m_ovf  = (frame_q.size() > 4);
            frame_q.delete();
            m_done = 0;
            m_miss = 0;
            upd    = 1;
        end else begin
            m_miss = m_miss + 1;
            if (m_miss == HOLD) begin
                m_rom  = 16'hFFFF;
                m_miss = 0;
                upd    = 1;
            end
        end
    endfunction

    function automatic void model_beat(input int c, input bit l);
        frame_q.push_back(c);
        if (l) m_done = 1;
    endfunction

    task automatic send_beat(input logic [3:0] c, input logic l);
        int n;
        n = 0;
        @(negedge sclk);
        bus.digit_valid = 1'b1;
        bus.digit_class = c;
        bus.digit_last  = l;
        while (bus.digit_ready !== 1'b1 && n < 50) begin
            @(negedge sclk);
            n++;
        end
        total++;
        if (n >= 50) begin
            bad++;
            $display("FAIL beat_accept_timeout ready=%b required=1", bus.digit_ready);
        end
        @(negedge sclk);
        bus.digit_valid = 1'b0;
        bus.digit_last  = 1'b0;
        model_beat(int'(c), l);
    endtask

    task automatic vs_pulse(output logic upd1, output int upd_cnt, output logic [15:0] rs,
                            output logic ov, output bit exp_upd);
        @(negedge sclk);
        vga_vsync = 1'b1;
        @(negedge sclk);
        upd1    = sel_update;
        rs      = rom_sel;
        ov      = ovf_o;
        upd_cnt = int'(sel_update);
        repeat (3) begin
            @(negedge sclk);
            upd_cnt += int'(sel_update);
        end
        vga_vsync = 1'b0;
        @(negedge sclk);
        upd_cnt += int'(sel_update);
        model_vs(exp_upd);
    endtask

    task automatic collide(input logic [3:0] c, output logic upd1, output logic [15:0] rs,
                           output logic rdy, output bit exp_upd);
        @(negedge sclk);
        bus.digit_valid = 1'b1;
        bus.digit_class = c;
        bus.digit_last  = 1'b1;
        vga_vsync       = 1'b1;
        @(negedge sclk);
        upd1 = sel_update;
        rs   = rom_sel;
        rdy  = bus.digit_ready;
        bus.digit_valid = 1'b0;
        bus.digit_last  = 1'b0;
        repeat (2) @(negedge sclk);
        vga_vsync = 1'b0;
        @(negedge sclk);
        model_vs(exp_upd);
        model_beat(int'(c), 1'b1);
    endtask

    task automatic test_reset();
        s_rst_n = 1'b1;
        vga_vsync = 1'b0;
        bus.digit_valid = 1'b0;
        bus.digit_class = 4'h0;
        bus.digit_last  = 1'b0;
        #2 s_rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge sclk);
        total++;
        if (rom_sel !== 16'hFFFF) begin bad++; $display("FAIL reset_rom_sel got=%h want=ffff", rom_sel); end
        total++;
        if (bus.digit_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", bus.digit_ready); end
        total++;
        if (sel_update !== 1'b0 || ovf_o !== 1'b0) begin
            bad++; $display("FAIL reset_flags upd=%b ovf=%b want=0,0", sel_update, ovf_o);
        end
        s_rst_n = 1'b1;
        @(negedge sclk);
        total++;
        if (bus.digit_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", bus.digit_ready); end
    endtask

    task automatic test_normal_commit();
        logic u1; int uc; logic [15:0] rs; logic ov; bit eu;
        send_beat(4'd3, 1'b0);
        send_beat(4'd7, 1'b0);
        send_beat(4'd1, 1'b0);
        send_beat(4'd9, 1'b1);
        total++;
        if (bus.digit_ready !== 1'b0) begin bad++; $display("FAIL normal_ready_after_last got=%b want=0", bus.digit_ready); end
        repeat (3) @(negedge sclk);
        total++;
        if (bus.digit_ready !== 1'b0 || sel_update !== 1'b0) begin
            bad++; $display("FAIL normal_idle_done ready=%b upd=%b want=0,0", bus.digit_ready, sel_update);
        end
        vs_pulse(u1, uc, rs, ov, eu);
        total++;
        if (rs !== 16'h9173) begin bad++; $display("FAIL normal_rom_sel got=%h want=9173", rs); end
        total++;
        if (u1 !== 1'b1 || uc != 1) begin bad++; $display("FAIL normal_update first=%b count=%0d want=1,1", u1, uc); end
        total++;
        if (ov !== 1'b0) begin bad++; $display("FAIL normal_ovf got=%b want=0", ov); end
        total++;
        if (bus.digit_ready !== 1'b1) begin bad++; $display("FAIL normal_ready_after_commit got=%b want=1", bus.digit_ready); end
    endtask

    task automatic test_reject_partial();
        logic u1; int uc; logic [15:0] rs; logic ov; bit eu;
        send_beat(4'd5, 1'b0);
        send_beat(4'd12, 1'b1);
        vs_pulse(u1, uc, rs, ov, eu);
        total++;
        if (rs !== 16'hFFF5 || uc != 1) begin bad++; $display("FAIL reject_rom_sel got=%h/%0d want=fff5/1", rs, uc); end
    endtask

    task automatic test_overflow();
        logic u1; int uc; logic [15:0] rs; logic ov; bit eu;
        for (int i = 1; i <= 6; i++) send_beat(4'(i), (i == 6));
        vs_pulse(u1, uc, rs, ov, eu);
        total++;
        if (rs !== 16'h4321) begin bad++; $display("FAIL ovf_rom_sel got=%h want=4321", rs); end
        total++;
        if (ov !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", ov); end
        send_beat(4'd8, 1'b1);
        vs_pulse(u1, uc, rs, ov, eu);
        total++;
        if (rs !== 16'hFFF8 || ov !== 1'b0) begin bad++; $display("FAIL ovf_clean got=%h/%b want=fff8/0", rs, ov); end
    endtask

    task automatic test_timeout();
        logic u1; int uc; logic [15:0] rs; logic ov; bit eu;
        for (int i = 0; i < 4; i++) send_beat(4'd2, (i == 3));
        vs_pulse(u1, uc, rs, ov, eu);
        total++;
        if (rs !== 16'h2222) begin bad++; $display("FAIL timeout_commit got=%h want=2222", rs); end
        for (int r = 1; r <= HOLD; r++) begin
            vs_pulse(u1, uc, rs, ov, eu);
            total++;
            if (r < HOLD && (u1 !== 1'b0 || uc != 0 || rs !== 16'h2222)) begin
                bad++; $display("FAIL timeout_early rise=%0d upd=%b cnt=%0d rom=%h want=0,0,2222", r, u1, uc, rs);
            end else if (r == HOLD && (u1 !== 1'b1 || uc != 1 || rs !== 16'hFFFF)) begin
                bad++; $display("FAIL timeout_blank rise=%0d upd=%b cnt=%0d rom=%h want=1,1,ffff", r, u1, uc, rs);
            end
        end
    endtask

    task automatic test_collision();
        logic u1; int uc; logic [15:0] rs; logic ov; bit eu; logic rdy;
        send_beat(4'd4, 1'b0);
        collide(4'd6, u1, rs, rdy, eu);
        total++;
        if (u1 !== 1'b0 || rs !== 16'hFFFF) begin bad++; $display("FAIL collide_no_commit upd=%b rom=%h want=0,ffff", u1, rs); end
        total++;
        if (rdy !== 1'b0) begin bad++; $display("FAIL collide_ready got=%b want=0", rdy); end
        vs_pulse(u1, uc, rs, ov, eu);
        total++;
        if (rs !== 16'hFF64 || uc != 1) begin bad++; $display("FAIL collide_commit got=%h/%0d want=ff64/1", rs, uc); end
    endtask

    task automatic test_reset_midrun();
        logic u1; int uc; logic [15:0] rs; logic ov; bit eu;
        send_beat(4'd5, 1'b0);
        @(negedge sclk);
        #2 s_rst_n = 1'b0;
        #1;
        total++;
        if (rom_sel !== 16'hFFFF || bus.digit_ready !== 1'b0 || sel_update !== 1'b0) begin
            bad++; $display("FAIL midrun_reset rom=%h ready=%b upd=%b want=ffff,0,0", rom_sel, bus.digit_ready, sel_update);
        end
        model_reset();
        repeat (2) @(negedge sclk);
        s_rst_n = 1'b1;
        @(negedge sclk);
        total++;
        if (bus.digit_ready !== 1'b1) begin bad++; $display("FAIL midrun_release_ready got=%b want=1", bus.digit_ready); end
        send_beat(4'd8, 1'b1);
        vs_pulse(u1, uc, rs, ov, eu);
        total++;
        if (rs !== 16'hFFF8) begin bad++; $display("FAIL midrun_shadow_lost got=%h want=fff8", rs); end
    endtask

    task automatic test_random();
        logic u1; int uc; logic [15:0] rs; logic ov; bit eu; logic rdy;
        for (int f = 0; f < 24; f++) begin
            int n, m;
            n = $urandom_range(1, 6);
            m = $urandom_range(0, 3);
            for (int i = 0; i < n - 1; i++) send_beat(4'($urandom_range(0, 15)), 1'b0);
            for (int k = 0; k < m; k++) begin
                vs_pulse(u1, uc, rs, ov, eu);
                total++;
                if (u1 !== logic'(eu) || uc != int'(eu) || rs !== m_rom || ov !== m_ovf) begin
                    bad++; $display("FAIL rand_miss f=%0d upd=%b cnt=%0d rom=%h ovf=%b want=%b,%0d,%h,%b",
                                    f, u1, uc, rs, ov, eu, int'(eu), m_rom, m_ovf);
                end
            end
            if ($urandom_range(0, 2) == 0) begin
                collide(4'($urandom_range(0, 15)), u1, rs, rdy, eu);
                total++;
                if (u1 !== logic'(eu) || rs !== m_rom || rdy !== 1'b0) begin
                    bad++; $display("FAIL rand_collide f=%0d upd=%b rom=%h rdy=%b want=%b,%h,0", f, u1, rs, rdy, eu, m_rom);
                end
            end else begin
                send_beat(4'($urandom_range(0, 15)), 1'b1);
            end
            vs_pulse(u1, uc, rs, ov, eu);
            total++;
            if (u1 !== 1'b1 || uc != 1 || rs !== m_rom || ov !== m_ovf || !eu) begin
                bad++; $display("FAIL rand_commit f=%0d upd=%b cnt=%0d rom=%h ovf=%b want=1,1,%h,%b",
                                f, u1, uc, rs, ov, m_rom, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal_commit();
        test_reject_partial();
        test_overflow();
        test_timeout();
        test_collision();
        test_reset_midrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
